// File: rtl/fpdiv_pkg.sv
// Shared types and helpers for the iterative floating-point divider.
// Rounding mode is selected in fp_div_rne by the FPDIV_RNE_EN macro.
package fpdiv_pkg;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_t;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    DIVIDE,
    ROUND,
    DONE
  } fpdiv_state_t;

  typedef struct packed {
    logic dbz;
    logic zbz;
    logic ovf;
    logic unf;
    logic inexact;
  } fpdiv_flags_t;

  function automatic int unsigned bias(input int unsigned ebits);
    return (32'd1 << (ebits - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: all-ones exponent plus mantissa MSB, right-aligned.
  function automatic logic [127:0] qnan(input int unsigned ebits, input int unsigned mbits);
    logic [127:0] ones;
    ones = (128'd1 << (ebits + 1)) - 128'd1;
    return ones << (mbits - 1);
  endfunction

endpackage

// File: rtl/fpdiv_mant_iter.sv
// Restoring mantissa divider: one quotient bit per step, MBITS+2 steps
// (MBITS+1 significant bits plus a guard bit); exposes fraction, guard and sticky.
module fpdiv_mant_iter
  import fpdiv_pkg::*;
#(
  parameter int unsigned MBITS = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [MBITS:0]   dividend_i,
  input  logic [MBITS:0]   divisor_i,
  input  logic             prenorm_i,
  output logic [MBITS:0]   quot_o,
  output logic             rem_nz_o,
  output logic             done_o
);

  localparam int unsigned NQ = MBITS + 2;
  localparam int unsigned CW = $clog2(NQ + 1);

  logic [MBITS+1:0] rem_q, rem_d, rem_sub;
  logic [MBITS:0]   div_q, div_d;
  logic [MBITS:0]   quot_q, quot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ge;

  always_comb begin
    rem_d   = rem_q;
    div_d   = div_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    ge      = (rem_q >= {1'b0, div_q});
    rem_sub = ge ? (rem_q - {1'b0, div_q}) : rem_q;
    if (load_i) begin
      rem_d  = prenorm_i ? {dividend_i, 1'b0} : {1'b0, dividend_i};
      div_d  = divisor_i;
      quot_d = '0;
      cnt_d  = CW'(NQ);
    end else if (step_i && (cnt_q != '0)) begin
      // Leading quotient bit is always 1 after prenormalising, so it falls off the top.
      quot_d = {quot_q[MBITS-1:0], ge};
      rem_d  = rem_sub << 1;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot_o   = quot_q;
  assign rem_nz_o = |rem_q;
  assign done_o   = (cnt_q == '0);

endmodule

// File: rtl/fp_div_rne.sv
// Parametrised IEEE-754 divider with fixed MBITS+5 cycle latency.
// Define FPDIV_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp_div_rne
  import fpdiv_pkg::*;
#(
  parameter  int unsigned EBITS = 8,
  parameter  int unsigned MBITS = 23,
  localparam int unsigned WIDTH = EBITS + MBITS + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] C,
  output logic             dbz,
  output logic             zbz,
  output logic             ovf,
  output logic             unf,
  output logic             inexact
);

  localparam int unsigned EW      = EBITS + 2;
  localparam int unsigned DIV_CYC = MBITS + 3;
  localparam int unsigned CW      = $clog2(DIV_CYC);
  localparam int unsigned EMAX    = (1 << EBITS) - 1;
  localparam logic signed [EW-1:0] BIAS_E = EW'(bias(EBITS));
  localparam logic signed [EW-1:0] EMAX_E = EW'(EMAX);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic [WIDTH-1:0]     QNAN   = WIDTH'(qnan(EBITS, MBITS));

  fpdiv_state_t     state_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, c_d;
  fp_class_t        ca_q, cb_q, cls_a, cls_b;
  logic             s_q, busy_q, valid_q;
  logic signed [EW-1:0] e_q, e_calc, e_r;
  logic [CW-1:0]    cnt_q;
  fpdiv_flags_t     flg_q, flg_d;

  logic [EBITS-1:0] ea, eb;
  logic [MBITS:0]   ma, mb;
  logic             lt;

  logic [MBITS:0]   quot;
  logic             rem_nz, div_done;
  logic             guard, sticky, inc;
  logic [MBITS:0]   frac_sum;

  function automatic fp_class_t classify(input logic [EBITS-1:0] e, input logic [MBITS-1:0] m);
    if (e == '0)      return ZERO;
    else if (e == '1) return (m == '0) ? INF : NAN;
    else              return NORM;
  endfunction

  always_comb begin
    ea     = a_q[WIDTH-2 -: EBITS];
    eb     = b_q[WIDTH-2 -: EBITS];
    ma     = {1'b1, a_q[MBITS-1:0]};
    mb     = {1'b1, b_q[MBITS-1:0]};
    cls_a  = classify(ea, a_q[MBITS-1:0]);
    cls_b  = classify(eb, b_q[MBITS-1:0]);
    lt     = (ma < mb);
    e_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E
             - $signed({{(EW-1){1'b0}}, lt});
  end

  fpdiv_mant_iter #(
    .MBITS(MBITS)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .load_i    ((state_q == CLASSIFY) && (cls_a == NORM) && (cls_b == NORM)),
    .step_i    (state_q == DIVIDE),
    .dividend_i(ma),
    .divisor_i (mb),
    .prenorm_i (lt),
    .quot_o    (quot),
    .rem_nz_o  (rem_nz),
    .done_o    (div_done)
  );

  always_comb begin
    guard  = quot[0];
    sticky = rem_nz;
`ifdef FPDIV_RNE_EN
    inc = guard & (sticky | quot[1]);
`else
    inc = 1'b0;
`endif
    // A carry out of the fraction leaves the low bits zero; only the exponent bumps.
    frac_sum = {1'b0, quot[MBITS:1]} + (MBITS+1)'(inc);
    e_r      = e_q + $signed({{(EW-1){1'b0}}, frac_sum[MBITS]});

    c_d   = {s_q, e_r[EBITS-1:0], frac_sum[MBITS-1:0]};
    flg_d = '0;
    if ((ca_q == NAN) || (cb_q == NAN) || ((ca_q == ZERO) && (cb_q == ZERO)) ||
        ((ca_q == INF) && (cb_q == INF))) begin
      c_d       = QNAN;
      flg_d.zbz = 1'b1;
    end else if (cb_q == ZERO) begin
      c_d       = {s_q, {EBITS{1'b1}}, {MBITS{1'b0}}};
      flg_d.dbz = 1'b1;
    end else if (ca_q == INF) begin
      c_d = {s_q, {EBITS{1'b1}}, {MBITS{1'b0}}};
    end else if ((cb_q == INF) || (ca_q == ZERO)) begin
      c_d = {s_q, {(WIDTH-1){1'b0}}};
    end else if (e_r >= EMAX_E) begin
      c_d           = {s_q, {EBITS{1'b1}}, {MBITS{1'b0}}};
      flg_d.ovf     = 1'b1;
      flg_d.inexact = 1'b1;
    end else if (e_r < ONE_E) begin
      c_d           = {s_q, {(WIDTH-1){1'b0}}};
      flg_d.unf     = 1'b1;
      flg_d.inexact = 1'b1;
    end else begin
      flg_d.inexact = guard | sticky;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ca_q    <= ZERO;
      cb_q    <= ZERO;
      s_q     <= 1'b0;
      e_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      c_q     <= '0;
      flg_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            busy_q  <= 1'b1;
            state_q <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          ca_q    <= cls_a;
          cb_q    <= cls_b;
          s_q     <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          e_q     <= e_calc;
          cnt_q   <= '0;
          state_q <= DIVIDE;
        end
        DIVIDE: begin
          if ((cnt_q == CW'(DIV_CYC - 1)) && div_done) state_q <= ROUND;
          else cnt_q <= cnt_q + CW'(1);
        end
        ROUND: begin
          c_q     <= c_d;
          flg_q   <= flg_d;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign C       = c_q;
  assign dbz     = flg_q.dbz;
  assign zbz     = flg_q.zbz;
  assign ovf     = flg_q.ovf;
  assign unf     = flg_q.unf;
  assign inexact = flg_q.inexact;

endmodule

// File: tb/tb_fp_div_rne.sv
// Directed bench for fp_div_rne (single precision), latency, flags and robustness.
// Expected rounding of 1/3 follows the FPDIV_RNE_EN macro.
module tb_fp_div_rne;

  localparam int LAT = 28;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] A, B, C;
  logic        busy, valid, dbz, zbz, ovf, unf, inexact;
  int          n_assert = 0;
  int          n_fail   = 0;

`ifdef FPDIV_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  always #5 clk = ~clk;

  fp_div_rne #(.EBITS(8), .MBITS(23)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .valid(valid), .C(C),
    .dbz(dbz), .zbz(zbz), .ovf(ovf), .unf(unf), .inexact(inexact)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flags packed as {dbz, zbz, ovf, unf, inexact}.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_c, input logic [4:0] exp_f);
    int lat;
    lat = 0;
    @(negedge clk);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= LAT + 10; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".lat"}, lat, LAT);
    chk({tag, ".C"}, C, exp_c);
    chk({tag, ".flags"}, {27'b0, dbz, zbz, ovf, unf, inexact}, {27'b0, exp_f});
    @(posedge clk);
    #1 chk({tag, ".pulse"}, {31'b0, valid}, 32'd0);
  endtask

  initial begin
    int lat, extra;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy_valid", {30'b0, busy, valid}, 32'd0);
    chk("reset.C", C, 32'd0);
    chk("reset.flags", {27'b0, dbz, zbz, ovf, unf, inexact}, 32'd0);
    @(negedge clk) rst = 1'b0;

    op("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
    op("one_third",   32'h3F800000, 32'h40400000, THIRD,        5'b00001);
    op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b10000);
    op("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 5'b10000);
    op("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 5'b01000);
    op("inf_inf",     32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b01000);
    op("nan_in",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b01000);
    op("inf_by_x",    32'h7F800000, 32'hC0000000, 32'hFF800000, 5'b00000);
    op("x_by_inf",    32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000);
    op("subnorm_ftz", 32'h80400000, 32'h3F800000, 32'h80000000, 5'b00000);
    op("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101);
    op("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 5'b00011);

    // start pulsed while busy must be ignored and never queued
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int i = 1; i <= LAT + 10; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (valid) begin
        lat = i;
        break;
      end
      if (i == 5) begin
        A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
      end
    end
    chk("busy_ign.lat", lat, LAT);
    chk("busy_ign.C", C, 32'h40400000);
    chk("busy_ign.flags", {27'b0, dbz, zbz, ovf, unf, inexact}, 32'd0);
    extra = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(posedge clk);
      #1 if (valid) extra++;
    end
    chk("busy_ign.no_queue", extra, 0);
    chk("busy_ign.idle", {31'b0, busy}, 32'd0);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst.busy_valid", {30'b0, busy, valid}, 32'd0);
    chk("midrst.C", C, 32'd0);
    chk("midrst.flags", {27'b0, dbz, zbz, ovf, unf, inexact}, 32'd0);
    @(negedge clk) rst = 1'b0;
    extra = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(posedge clk);
      #1 if (valid || busy) extra++;
    end
    chk("midrst.no_valid", extra, 0);
    op("after_rst", 32'h3F800000, 32'h40400000, THIRD, 5'b00001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
